// File: rtl/execute_stage_pkg.sv
// Shared encodings for the RV32IM execute stage: op classes, func3 codes, divider states.
package execute_stage_pkg;

    localparam logic [2:0] OpAlu    = 3'd0;
    localparam logic [2:0] OpBranch = 3'd1;
    localparam logic [2:0] OpJal    = 3'd2;
    localparam logic [2:0] OpJalr   = 3'd3;
    localparam logic [2:0] OpLui    = 3'd4;
    localparam logic [2:0] OpAuipc  = 3'd5;
    localparam logic [2:0] OpMulDiv = 3'd6;

    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;

    localparam logic [2:0] F3Mul    = 3'b000;
    localparam logic [2:0] F3Mulh   = 3'b001;
    localparam logic [2:0] F3Mulhsu = 3'b010;
    localparam logic [2:0] F3Mulhu  = 3'b011;
    localparam logic [2:0] F3Div    = 3'b100;
    localparam logic [2:0] F3Divu   = 3'b101;
    localparam logic [2:0] F3Rem    = 3'b110;
    localparam logic [2:0] F3Remu   = 3'b111;

    localparam logic [1:0] DivIdle = 2'd0;
    localparam logic [1:0] DivRun  = 2'd1;
    localparam logic [1:0] DivDone = 2'd2;

    function automatic logic is_div_op(input logic [2:0] op_type, input logic [2:0] func3);
        return (op_type == OpMulDiv) &&
               (func3 == F3Div || func3 == F3Divu || func3 == F3Rem || func3 == F3Remu);
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage; master = pipeline side, slave = EX.
interface execute_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_Valid;
    logic [2:0]      i_OpType;
    logic [2:0]      i_Func3;
    logic            i_Func7b5;
    logic            i_AluSrc;
    logic [XLEN-1:0] i_Rs1Data;
    logic [XLEN-1:0] i_Rs2Data;
    logic [XLEN-1:0] i_Imm;
    logic [XLEN-1:0] i_Pc;
    logic            i_Load;
    logic            i_MemSrc;
    logic            i_RegSrc;
    logic [1:0]      i_ResultSrc;
    logic [4:0]      i_Rd;
    logic            i_Stall;
    logic            i_Flush;

    logic            o_Busy;
    logic            o_BranchTaken;
    logic [XLEN-1:0] o_BranchTarget;
    logic [XLEN-1:0] o_ResultM;
    logic [XLEN-1:0] o_DataStoreM;
    logic [XLEN-1:0] o_PcM;
    logic [2:0]      o_Func3M;
    logic            o_LoadM;
    logic            o_MemSrcM;
    logic            o_RegSrcM;
    logic [1:0]      o_ResultSrcM;
    logic [4:0]      o_RdM;

    modport master (
        output i_Valid, i_OpType, i_Func3, i_Func7b5, i_AluSrc, i_Rs1Data, i_Rs2Data, i_Imm,
               i_Pc, i_Load, i_MemSrc, i_RegSrc, i_ResultSrc, i_Rd, i_Stall, i_Flush,
        input  o_Busy, o_BranchTaken, o_BranchTarget, o_ResultM, o_DataStoreM, o_PcM,
               o_Func3M, o_LoadM, o_MemSrcM, o_RegSrcM, o_ResultSrcM, o_RdM
    );

    modport slave (
        input  i_Valid, i_OpType, i_Func3, i_Func7b5, i_AluSrc, i_Rs1Data, i_Rs2Data, i_Imm,
               i_Pc, i_Load, i_MemSrc, i_RegSrc, i_ResultSrc, i_Rd, i_Stall, i_Flush,
        output o_Busy, o_BranchTaken, o_BranchTarget, o_ResultM, o_DataStoreM, o_PcM,
               o_Func3M, o_LoadM, o_MemSrcM, o_RegSrcM, o_ResultSrcM, o_RdM
    );

endinterface

// File: rtl/div_unit.sv
// Restoring serial divider for DIV/DIVU/REM/REMU with special-case bypass and sign fix-up.
module div_unit
    import execute_stage_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic            flush,
    input  logic            stall,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic [XLEN-1:0] result
);
    localparam int unsigned CntW = $clog2(DIV_CYCLES);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic            quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d, is_rem_q, is_rem_d;
    logic            is_signed;
    logic [XLEN:0]   shifted, diff;

    assign is_signed = !(func3 == F3Divu || func3 == F3Remu);
    assign shifted   = {rem_q, quo_q[XLEN-1]};
    assign diff      = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        is_rem_d  = is_rem_q;
        case (state_q)
            DivIdle: begin
                if (req && !flush) begin
                    is_rem_d  = (func3 == F3Rem || func3 == F3Remu);
                    quo_neg_d = 1'b0;
                    rem_neg_d = 1'b0;
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        state_d = DivDone;
                    end else if (is_signed && dividend == MinNeg && divisor == '1) begin
                        quo_d   = MinNeg;
                        rem_d   = '0;
                        state_d = DivDone;
                    end else begin
                        quo_d     = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
                        dvs_d     = (is_signed && divisor[XLEN-1]) ? -divisor : divisor;
                        rem_d     = '0;
                        quo_neg_d = is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        rem_neg_d = is_signed && dividend[XLEN-1];
                        cnt_d     = '0;
                        state_d   = DivRun;
                    end
                end
            end
            DivRun: begin
                if (flush) begin
                    state_d = DivIdle;
                end else begin
                    // No borrow means the shifted partial remainder covers the divisor.
                    if (!diff[XLEN]) begin
                        rem_d = diff[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(DIV_CYCLES - 1)) begin
                        state_d = DivDone;
                    end
                end
            end
            DivDone: begin
                if (flush || !stall) begin
                    state_d = DivIdle;
                end
            end
            default: state_d = DivIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DivIdle;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            is_rem_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            is_rem_q  <= is_rem_d;
        end
    end

    assign busy   = rst_n && ((state_q == DivIdle && req) || state_q == DivRun);
    assign result = is_rem_q ? (rem_neg_q ? -rem_q : rem_q) : (quo_neg_q ? -quo_q : quo_q);

endmodule

// File: rtl/execute_stage.sv
// RV32IM execute stage: inline ALU, multiplier and branch unit, serial divider, EX/MEM register.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DIV_CYCLES = 32
) (
    input logic            clk,
    input logic            rst_n,
    execute_stage_if.slave bus
);
    logic [XLEN-1:0]   rs1, rs2, op_b, alu_result, mul_result, div_result, ex_result;
    logic [XLEN-1:0]   pc_imm, jalr_sum;
    logic signed [XLEN:0] mul_a, mul_b;
    logic [2*XLEN-1:0] mul_prod;
    logic              is_div, div_req, busy, cond_true, jump;

    assign rs1  = bus.i_Rs1Data;
    assign rs2  = bus.i_Rs2Data;
    assign op_b = bus.i_AluSrc ? bus.i_Imm : rs2;

    always_comb begin
        alu_result = '0;
        if (bus.i_Load || bus.i_MemSrc) begin
            alu_result = rs1 + op_b;
        end else begin
            unique case (bus.i_Func3)
                3'b000: alu_result = (bus.i_Func7b5 && !bus.i_AluSrc) ? rs1 - op_b : rs1 + op_b;
                3'b001: alu_result = rs1 << op_b[4:0];
                3'b010: alu_result = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(op_b)};
                3'b011: alu_result = {{(XLEN-1){1'b0}}, rs1 < op_b};
                3'b100: alu_result = rs1 ^ op_b;
                3'b101: alu_result = bus.i_Func7b5 ? $unsigned($signed(rs1) >>> op_b[4:0])
                                                   : rs1 >> op_b[4:0];
                3'b110: alu_result = rs1 | op_b;
                3'b111: alu_result = rs1 & op_b;
            endcase
        end
    end

    // A 33-bit signed operand per side covers all four signedness combinations.
    assign mul_a      = {(bus.i_Func3 == F3Mulh || bus.i_Func3 == F3Mulhsu) && rs1[XLEN-1], rs1};
    assign mul_b      = {(bus.i_Func3 == F3Mulh) && rs2[XLEN-1], rs2};
    assign mul_prod   = (2*XLEN)'(mul_a * mul_b);
    assign mul_result = (bus.i_Func3 == F3Mul) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    always_comb begin
        cond_true = 1'b0;
        unique case (bus.i_Func3)
            F3Beq:   cond_true = (rs1 == rs2);
            F3Bne:   cond_true = (rs1 != rs2);
            F3Blt:   cond_true = ($signed(rs1) < $signed(rs2));
            F3Bge:   cond_true = ($signed(rs1) >= $signed(rs2));
            F3Bltu:  cond_true = (rs1 < rs2);
            F3Bgeu:  cond_true = (rs1 >= rs2);
            default: cond_true = 1'b0;
        endcase
    end

    assign pc_imm   = bus.i_Pc + bus.i_Imm;
    assign jalr_sum = rs1 + bus.i_Imm;
    assign jump     = (bus.i_OpType == OpJal) || (bus.i_OpType == OpJalr);

    assign bus.o_BranchTaken  = rst_n && bus.i_Valid && !bus.i_Flush && !busy &&
                                ((bus.i_OpType == OpBranch && cond_true) || jump);
    assign bus.o_BranchTarget = (bus.i_OpType == OpJalr) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_imm;

    assign is_div  = is_div_op(bus.i_OpType, bus.i_Func3);
    assign div_req = bus.i_Valid && is_div;

    div_unit #(
        .XLEN       (XLEN),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (div_req),
        .flush    (bus.i_Flush),
        .stall    (bus.i_Stall),
        .func3    (bus.i_Func3),
        .dividend (rs1),
        .divisor  (rs2),
        .busy     (busy),
        .result   (div_result)
    );

    assign bus.o_Busy = busy;

    always_comb begin
        unique case (bus.i_OpType)
            OpJal, OpJalr: ex_result = bus.i_Pc + 32'd4;
            OpLui:         ex_result = bus.i_Imm;
            OpAuipc:       ex_result = pc_imm;
            OpMulDiv:      ex_result = is_div ? div_result : mul_result;
            default:       ex_result = alu_result;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_ResultM    <= '0;
            bus.o_DataStoreM <= '0;
            bus.o_PcM        <= '0;
            bus.o_Func3M     <= '0;
            bus.o_LoadM      <= 1'b0;
            bus.o_MemSrcM    <= 1'b0;
            bus.o_RegSrcM    <= 1'b0;
            bus.o_ResultSrcM <= '0;
            bus.o_RdM        <= '0;
        end else if (bus.i_Stall) begin
            // Hold every field.
        end else if (bus.i_Flush || busy || !bus.i_Valid) begin
            bus.o_ResultM    <= '0;
            bus.o_DataStoreM <= '0;
            bus.o_PcM        <= '0;
            bus.o_Func3M     <= '0;
            bus.o_LoadM      <= 1'b0;
            bus.o_MemSrcM    <= 1'b0;
            bus.o_RegSrcM    <= 1'b0;
            bus.o_ResultSrcM <= '0;
            bus.o_RdM        <= '0;
        end else begin
            bus.o_ResultM    <= ex_result;
            bus.o_DataStoreM <= rs2;
            bus.o_PcM        <= bus.i_Pc;
            bus.o_Func3M     <= bus.i_Func3;
            bus.o_LoadM      <= bus.i_Load;
            bus.o_MemSrcM    <= bus.i_MemSrc;
            bus.o_RegSrcM    <= bus.i_RegSrc;
            bus.o_ResultSrcM <= bus.i_ResultSrc;
            bus.o_RdM        <= bus.i_Rd;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: ALU, branches, mul, div, stall, flush, reset.
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    execute_stage_if bus ();

    execute_stage #(
        .XLEN       (32),
        .DIV_CYCLES (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_Valid     = 1'b0;
        bus.i_OpType    = '0;
        bus.i_Func3     = '0;
        bus.i_Func7b5   = 1'b0;
        bus.i_AluSrc    = 1'b0;
        bus.i_Rs1Data   = '0;
        bus.i_Rs2Data   = '0;
        bus.i_Imm       = '0;
        bus.i_Pc        = '0;
        bus.i_Load      = 1'b0;
        bus.i_MemSrc    = 1'b0;
        bus.i_RegSrc    = 1'b0;
        bus.i_ResultSrc = '0;
        bus.i_Rd        = '0;
        bus.i_Stall     = 1'b0;
        bus.i_Flush     = 1'b0;
    endtask

    task automatic drive(input logic [2:0] op, f3, input logic f7, src,
                         input logic [31:0] rs1, rs2, imm, pc, input logic [4:0] rd);
        bus.i_Valid     = 1'b1;
        bus.i_OpType    = op;
        bus.i_Func3     = f3;
        bus.i_Func7b5   = f7;
        bus.i_AluSrc    = src;
        bus.i_Rs1Data   = rs1;
        bus.i_Rs2Data   = rs2;
        bus.i_Imm       = imm;
        bus.i_Pc        = pc;
        bus.i_Load      = 1'b0;
        bus.i_MemSrc    = 1'b0;
        bus.i_RegSrc    = 1'b1;
        bus.i_ResultSrc = '0;
        bus.i_Rd        = rd;
    endtask

    task automatic run_div(input string tag, input logic [2:0] f3, input logic [31:0] a, b,
                           input int exp_busy, input logic [31:0] exp_res);
        int n = 0;
        drive(OpMulDiv, f3, 1'b0, 1'b0, a, b, 32'h0, 32'h80, 5'd9);
        #1;
        while (bus.o_Busy && n < 64) begin
            n++;
            tick();
        end
        check({tag, " busy_cycles"}, 32'(n), 32'(exp_busy));
        check({tag, " bubble_regsrc"}, {31'b0, bus.o_RegSrcM}, 32'h0);
        tick();
        idle();
        check({tag, " result"}, bus.o_ResultM, exp_res);
        check({tag, " rd"}, {27'b0, bus.o_RdM}, 32'd9);
    endtask

    initial begin
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset result", bus.o_ResultM, 32'h0);
        check("reset rd", {27'b0, bus.o_RdM}, 32'h0);
        check("reset regsrc", {31'b0, bus.o_RegSrcM}, 32'h0);
        drive(OpMulDiv, F3Div, 1'b0, 1'b0, 32'd7, 32'd2, 32'h0, 32'h0, 5'd1);
        #1 check("reset busy", {31'b0, bus.o_Busy}, 32'h0);
        drive(OpJal, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h40, 32'h300, 5'd1);
        #1 check("reset taken", {31'b0, bus.o_BranchTaken}, 32'h0);
        idle();
        #1 rst_n = 1'b1;
        tick();

        drive(OpAlu, 3'b000, 1'b0, 1'b1, 32'd5, 32'h1234, 32'hFFFF_FFF9, 32'h40, 5'd7);
        bus.i_ResultSrc = 2'b01;
        tick();
        check("add result", bus.o_ResultM, 32'hFFFF_FFFE);
        check("add rd", {27'b0, bus.o_RdM}, 32'd7);
        check("add regsrc", {31'b0, bus.o_RegSrcM}, 32'h1);
        check("add resultsrc", {30'b0, bus.o_ResultSrcM}, 32'h1);
        check("add store data", bus.o_DataStoreM, 32'h1234);
        check("add pc", bus.o_PcM, 32'h40);

        drive(OpAlu, 3'b000, 1'b1, 1'b0, 32'd10, 32'd3, 32'h0, 32'h0, 5'd2);
        tick();
        check("sub", bus.o_ResultM, 32'd7);
        drive(OpAlu, 3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 32'd4, 32'h0, 5'd2);
        tick();
        check("sra", bus.o_ResultM, 32'hF800_0000);
        drive(OpAlu, 3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 32'd4, 32'h0, 5'd2);
        tick();
        check("srl", bus.o_ResultM, 32'h0800_0000);
        drive(OpAlu, 3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 5'd2);
        tick();
        check("slt", bus.o_ResultM, 32'd1);
        drive(OpAlu, 3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 5'd2);
        tick();
        check("sltu", bus.o_ResultM, 32'd0);
        drive(OpAlu, F3Lw, 1'b0, 1'b1, 32'h100, 32'h0, 32'd8, 32'h0, 5'd3);
        bus.i_Load = 1'b1;
        tick();
        check("load addr", bus.o_ResultM, 32'h108);
        check("load flag", {31'b0, bus.o_LoadM}, 32'h1);
        check("load func3", {29'b0, bus.o_Func3M}, 32'h2);
        drive(OpLui, 3'b000, 1'b0, 1'b1, 32'h0, 32'h0, 32'hABCD_E000, 32'h0, 5'd4);
        tick();
        check("lui", bus.o_ResultM, 32'hABCD_E000);
        drive(OpAuipc, 3'b000, 1'b0, 1'b1, 32'h0, 32'h0, 32'h2000, 32'h1000, 5'd4);
        tick();
        check("auipc", bus.o_ResultM, 32'h3000);

        drive(OpBranch, F3Blt, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd0);
        #1;
        check("blt taken", {31'b0, bus.o_BranchTaken}, 32'h1);
        check("blt target", bus.o_BranchTarget, 32'h120);
        bus.i_Flush = 1'b1;
        #1 check("blt flushed", {31'b0, bus.o_BranchTaken}, 32'h0);
        bus.i_Flush = 1'b0;
        bus.i_Func3 = F3Bltu;
        #1 check("bltu not taken", {31'b0, bus.o_BranchTaken}, 32'h0);
        drive(OpJal, 3'b000, 1'b0, 1'b1, 32'h0, 32'h0, 32'h40, 32'h300, 5'd1);
        #1;
        check("jal taken", {31'b0, bus.o_BranchTaken}, 32'h1);
        check("jal target", bus.o_BranchTarget, 32'h340);
        tick();
        check("jal link", bus.o_ResultM, 32'h304);
        drive(OpJalr, 3'b000, 1'b0, 1'b1, 32'h201, 32'h0, 32'd4, 32'h500, 5'd1);
        #1 check("jalr target", bus.o_BranchTarget, 32'h204);
        tick();
        check("jalr link", bus.o_ResultM, 32'h504);

        drive(OpMulDiv, F3Mul, 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'h0, 32'h0, 5'd5);
        tick();
        check("mul", bus.o_ResultM, 32'hFFFF_FFEB);
        drive(OpMulDiv, F3Mulh, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd5);
        tick();
        check("mulh", bus.o_ResultM, 32'h0);
        drive(OpMulDiv, F3Mulhu, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd5);
        tick();
        check("mulhu", bus.o_ResultM, 32'hFFFF_FFFE);
        drive(OpMulDiv, F3Mulhsu, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd6);
        tick();
        check("mulhsu", bus.o_ResultM, 32'hFFFF_FFFF);

        bus.i_Stall = 1'b1;
        drive(OpAlu, 3'b000, 1'b0, 1'b1, 32'd1, 32'h0, 32'd2, 32'h0, 5'd8);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall hold result", bus.o_ResultM, 32'hFFFF_FFFF);
            check("stall hold rd", {27'b0, bus.o_RdM}, 32'd6);
        end
        bus.i_Stall = 1'b0;
        tick();
        check("after stall", bus.o_ResultM, 32'd3);

        run_div("div", F3Div, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        run_div("rem", F3Rem, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
        run_div("divu0", F3Divu, 32'd9, 32'd0, 1, 32'hFFFF_FFFF);
        run_div("remu0", F3Remu, 32'd9, 32'd0, 1, 32'd9);
        run_div("div ovf", F3Div, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);

        drive(OpMulDiv, F3Div, 1'b0, 1'b0, 32'd100, 32'd3, 32'h0, 32'h0, 5'd10);
        #1;
        repeat (10) tick();
        check("flush pre busy", {31'b0, bus.o_Busy}, 32'h1);
        bus.i_Flush = 1'b1;
        tick();
        idle();
        #1;
        check("flush busy", {31'b0, bus.o_Busy}, 32'h0);
        check("flush regsrc", {31'b0, bus.o_RegSrcM}, 32'h0);
        check("flush rd", {27'b0, bus.o_RdM}, 32'h0);
        drive(OpAlu, 3'b000, 1'b0, 1'b1, 32'd1, 32'h0, 32'd2, 32'h0, 5'd4);
        tick();
        check("post flush add", bus.o_ResultM, 32'd3);
        check("post flush rd", {27'b0, bus.o_RdM}, 32'd4);

        bus.i_Stall = 1'b1;
        drive(OpMulDiv, F3Divu, 1'b0, 1'b0, 32'd100, 32'd3, 32'h0, 32'h0, 5'd11);
        repeat (5) tick();
        check("mid div hold", bus.o_ResultM, 32'd3);
        #3 rst_n = 1'b0;
        #1;
        check("async rst result", bus.o_ResultM, 32'h0);
        check("async rst rd", {27'b0, bus.o_RdM}, 32'h0);
        check("async rst regsrc", {31'b0, bus.o_RegSrcM}, 32'h0);
        check("async rst busy", {31'b0, bus.o_Busy}, 32'h0);
        idle();
        #1 rst_n = 1'b1;
        tick();
        check("post rst idle", {31'b0, bus.o_Busy}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
